// File: rtl/io_input_conditioner_pkg.sv
// Shared constants for the KEY/SW input conditioning path.
// Holds bus addresses, default widths and the keyOut field layout.
package io_input_conditioner_pkg;

  localparam logic [31:0] ADDR_KEY = 32'h0000_FFF0;
  localparam logic [31:0] ADDR_SW  = 32'h0000_FFF4;

  localparam int KEY_BITS_DEF = 4;
  localparam int SW_BITS_DEF  = 10;

  localparam int WORD_W        = 32;
  localparam int KEY_STATE_LSB = 0;
  localparam int KEY_EVT_LSB   = 4;

endpackage

// File: rtl/io_input_conditioner_if.sv
// Board-side pins, event-clear strobe and the conditioned
// KEY/SW words, grouped for the IO controller.
interface io_input_conditioner_if
  import io_input_conditioner_pkg::*;
#(
  parameter int KEY_BITS = KEY_BITS_DEF,
  parameter int SW_BITS  = SW_BITS_DEF
);

  logic [KEY_BITS-1:0] keyRaw;
  logic [SW_BITS-1:0]  swRaw;
  logic                evtClrEn;
  logic [KEY_BITS-1:0] evtClrMask;
  logic [WORD_W-1:0]   keyOut;
  logic [WORD_W-1:0]   swOut;
  logic [KEY_BITS-1:0] keyPressPulse;

  modport master (
    output keyRaw,
    output swRaw,
    output evtClrEn,
    output evtClrMask,
    input  keyOut,
    input  swOut,
    input  keyPressPulse
  );

  modport slave (
    input  keyRaw,
    input  swRaw,
    input  evtClrEn,
    input  evtClrMask,
    output keyOut,
    output swOut,
    output keyPressPulse
  );

endinterface

// File: rtl/io_input_conditioner_debounce_bit.sv
// Two-flop synchroniser plus stable-level filter for one pin.
// accept is high in the cycle before stable flips.
module debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 20,
  parameter int   CNT_WIDTH       = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable,
  output logic accept
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1;
  logic                 sync2;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cntNxt;
  logic                 differs;
  logic                 atMax;

  assign differs = sync2 ^ stable;
  assign atMax   = (cnt == CNT_MAX);
  assign accept  = differs & atMax;

  // Any return to the stable level restarts the run.
  always_comb begin
    cntNxt = cnt;
    unique case (1'b1)
      !differs: cntNxt = '0;
      accept:   cntNxt = '0;
      default:  cntNxt = cnt + 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= RESET_LEVEL;
      sync2  <= RESET_LEVEL;
      stable <= RESET_LEVEL;
      cnt    <= '0;
    end else begin
      sync1  <= din;
      sync2  <= sync1;
      stable <= stable ^ accept;
      cnt    <= cntNxt;
    end
  end

endmodule

// File: rtl/io_input_conditioner.sv
// Debounced KEY/SW words with sticky press events and
// write-1-to-clear, feeding the memory-mapped read path.
module io_input_conditioner
  import io_input_conditioner_pkg::*;
#(
  parameter int KEY_BITS        = KEY_BITS_DEF,
  parameter int SW_BITS         = SW_BITS_DEF,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_WIDTH       = 16
) (
  input  logic clk,
  input  logic reset,
  io_input_conditioner_if.slave io
);

  logic [KEY_BITS-1:0] keyLvl;
  logic [KEY_BITS-1:0] keyAcc;
  logic [KEY_BITS-1:0] keyStateNxt;
  logic [KEY_BITS-1:0] pressEdge;
  logic [KEY_BITS-1:0] evtClr;
  logic [KEY_BITS-1:0] keyEvt;
  logic [KEY_BITS-1:0] evtNxt;
  logic [KEY_BITS-1:0] pulseQ;
  logic [SW_BITS-1:0]  swLvl;
  logic [SW_BITS-1:0]  swAcc;
  logic [SW_BITS-1:0]  swNxt;
  logic [WORD_W-1:0]   keyWord;
  logic [WORD_W-1:0]   keyOutQ;
  logic [WORD_W-1:0]   swOutQ;

  for (genvar i = 0; i < KEY_BITS; i++) begin : gKey
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH),
      .RESET_LEVEL    (1'b1)
    ) uDb (
      .clk   (clk),
      .reset (reset),
      .din   (io.keyRaw[i]),
      .stable(keyLvl[i]),
      .accept(keyAcc[i])
    );
  end

  for (genvar i = 0; i < SW_BITS; i++) begin : gSw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH),
      .RESET_LEVEL    (1'b0)
    ) uDb (
      .clk   (clk),
      .reset (reset),
      .din   (io.swRaw[i]),
      .stable(swLvl[i]),
      .accept(swAcc[i])
    );
  end

  // Keys are active-low; a press is released->pressed.
  assign keyStateNxt = ~(keyLvl ^ keyAcc);
  assign pressEdge   = keyAcc & keyLvl;
  assign swNxt       = swLvl ^ swAcc;

  // A press in the clearing cycle wins.
  assign evtClr = io.evtClrEn ? io.evtClrMask : '0;
  assign evtNxt = (keyEvt & ~evtClr) | pressEdge;

  assign keyWord =
    (WORD_W'(evtNxt) << KEY_EVT_LSB) |
    (WORD_W'(keyStateNxt) << KEY_STATE_LSB);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keyEvt  <= '0;
      pulseQ  <= '0;
      keyOutQ <= '0;
      swOutQ  <= '0;
    end else begin
      keyEvt  <= evtNxt;
      pulseQ  <= pressEdge;
      keyOutQ <= keyWord;
      swOutQ  <= WORD_W'(swNxt);
    end
  end

  assign io.keyOut        = keyOutQ;
  assign io.swOut         = swOutQ;
  assign io.keyPressPulse = pulseQ;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: directed scenarios plus random
// stimulus against a sliding-window reference model.
module tb_io_input_conditioner;
  import io_input_conditioner_pkg::*;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  io_input_conditioner_if #(.KEY_BITS(4), .SW_BITS(10)) aIf ();
  io_input_conditioner_if #(.KEY_BITS(4), .SW_BITS(10)) bIf ();

  io_input_conditioner #(
    .KEY_BITS(4), .SW_BITS(10),
    .DEBOUNCE_CYCLES(D), .CNT_WIDTH(16)
  ) dutA (
    .clk(clk), .reset(rst), .io(aIf.slave)
  );

  io_input_conditioner #(
    .KEY_BITS(4), .SW_BITS(10),
    .DEBOUNCE_CYCLES(1), .CNT_WIDTH(4)
  ) dutB (
    .clk(clk), .reset(rst), .io(bIf.slave)
  );

  // Model: a level is accepted once the last D synchronised
  // samples all disagree with the current accepted level.
  logic [3:0] mS1, mS2, mState, mEvt, mPulse;
  logic [9:0] sS1, sS2, sState;
  logic [3:0] hKey[$];
  logic [9:0] hSw[$];

  function automatic logic [31:0] expKey();
    return {24'd0, mEvt, mState};
  endfunction

  function automatic logic [31:0] expSw();
    return {22'd0, sState};
  endfunction

  task automatic model_reset();
    mS1 = '1; mS2 = '1;
    mState = '0; mEvt = '0; mPulse = '0;
    sS1 = '0; sS2 = '0; sState = '0;
    hKey.delete();
    hSw.delete();
  endtask

  task automatic model_edge();
    logic [3:0] nk, pe, clr;
    logic [9:0] ns;
    bit all;
    hKey.push_back(~mS2);
    hSw.push_back(sS2);
    if (hKey.size() > D) hKey.delete(0);
    if (hSw.size() > D) hSw.delete(0);
    nk = mState;
    ns = sState;
    if (hKey.size() == D) begin
      for (int i = 0; i < 4; i++) begin
        all = 1'b1;
        foreach (hKey[j]) if (hKey[j][i] == mState[i]) all = 1'b0;
        if (all) nk[i] = ~mState[i];
      end
      for (int i = 0; i < 10; i++) begin
        all = 1'b1;
        foreach (hSw[j]) if (hSw[j][i] == sState[i]) all = 1'b0;
        if (all) ns[i] = ~sState[i];
      end
    end
    pe = nk & ~mState;
    clr = aIf.evtClrEn ? aIf.evtClrMask : 4'h0;
    mEvt = (mEvt & ~clr) | pe;
    mPulse = pe;
    mState = nk;
    sState = ns;
    mS2 = mS1; mS1 = aIf.keyRaw;
    sS2 = sS1; sS1 = aIf.swRaw;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic test_reset();
    aIf.keyRaw = '1; aIf.swRaw = '0;
    aIf.evtClrEn = 1'b0; aIf.evtClrMask = '0;
    bIf.keyRaw = '1; bIf.swRaw = '0;
    bIf.evtClrEn = 1'b0; bIf.evtClrMask = '0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (aIf.keyOut !== 32'h0) begin
      errors++;
      $display("FAIL reset_key: got %h want 0", aIf.keyOut);
    end
    checks++;
    if (bIf.keyOut !== 32'h0) begin
      errors++;
      $display("FAIL reset_keyB: got %h want 0", bIf.keyOut);
    end
    step();
    step();
    rst = 1'b0;
    repeat (20) begin
      step();
      checks++;
      if (aIf.keyOut !== 32'h0) begin
        errors++;
        $display("FAIL idle_key: got %h want 0", aIf.keyOut);
      end
      checks++;
      if (aIf.swOut !== 32'h0) begin
        errors++;
        $display("FAIL idle_sw: got %h want 0", aIf.swOut);
      end
      checks++;
      if (aIf.keyPressPulse !== 4'h0) begin
        errors++;
        $display("FAIL idle_pulse: got %h want 0",
                 aIf.keyPressPulse);
      end
    end
  endtask

  task automatic test_press();
    logic [31:0] exp;
    logic [3:0] expP;
    aIf.keyRaw[0] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp = (e >= D + 2) ? 32'h11 : 32'h0;
      expP = (e == D + 2) ? 4'b0001 : 4'b0000;
      checks++;
      if (aIf.keyOut !== exp) begin
        errors++;
        $display("FAIL press_key e=%0d: got %h want %h",
                 e, aIf.keyOut, exp);
      end
      checks++;
      if (aIf.keyPressPulse !== expP) begin
        errors++;
        $display("FAIL press_pulse e=%0d: got %h want %h",
                 e, aIf.keyPressPulse, expP);
      end
    end
    aIf.keyRaw[0] = 1'b1;
    repeat (8) begin
      step();
      checks++;
      if (aIf.keyOut !== expKey()) begin
        errors++;
        $display("FAIL release_key: got %h want %h",
                 aIf.keyOut, expKey());
      end
      checks++;
      if (aIf.keyPressPulse !== 4'h0) begin
        errors++;
        $display("FAIL release_pulse: got %h want 0",
                 aIf.keyPressPulse);
      end
    end
    checks++;
    if (aIf.keyOut !== 32'h10) begin
      errors++;
      $display("FAIL released_key: got %h want 10", aIf.keyOut);
    end
  endtask

  task automatic test_glitch();
    logic [15:0] pat;
    int np;
    pat = 16'b1111_1111_1111_1000;
    for (int c = 0; c < 16; c++) begin
      aIf.keyRaw[1] = pat[c];
      step();
      checks++;
      if (aIf.keyOut !== 32'h10 || aIf.keyPressPulse !== 4'h0)
      begin
        errors++;
        $display("FAIL glitch c=%0d: got %h/%h want 10/0",
                 c, aIf.keyOut, aIf.keyPressPulse);
      end
    end
    pat = 16'b0000_0000_0000_0010;
    np = 0;
    for (int c = 0; c < 16; c++) begin
      aIf.keyRaw[1] = pat[c];
      step();
      np += int'(aIf.keyPressPulse[1]);
      checks++;
      if (aIf.keyOut !== expKey()) begin
        errors++;
        $display("FAIL bounce_key c=%0d: got %h want %h",
                 c, aIf.keyOut, expKey());
      end
    end
    checks++;
    if (np != 1) begin
      errors++;
      $display("FAIL bounce_count: got %0d want 1", np);
    end
    checks++;
    if (aIf.keyOut !== 32'h32) begin
      errors++;
      $display("FAIL bounce_final: got %h want 32", aIf.keyOut);
    end
  endtask

  task automatic test_evt_clear();
    aIf.keyRaw[1] = 1'b1;
    repeat (D + 3) step();
    checks++;
    if (aIf.keyOut !== 32'h30) begin
      errors++;
      $display("FAIL evt_pre: got %h want 30", aIf.keyOut);
    end
    for (int r = 0; r < 2; r++) begin
      aIf.evtClrEn = 1'b1;
      aIf.evtClrMask = 4'b0001;
      step();
      aIf.evtClrEn = 1'b0;
      aIf.evtClrMask = 4'b0000;
      checks++;
      if (aIf.keyOut !== 32'h20) begin
        errors++;
        $display("FAIL evt_clr r=%0d: got %h want 20",
                 r, aIf.keyOut);
      end
    end
    aIf.keyRaw[2] = 1'b0;
    repeat (D + 1) step();
    aIf.evtClrEn = 1'b1;
    aIf.evtClrMask = 4'b0100;
    step();
    checks++;
    if (aIf.keyOut !== 32'h64) begin
      errors++;
      $display("FAIL evt_setwins: got %h want 64", aIf.keyOut);
    end
    checks++;
    if (aIf.keyPressPulse !== 4'b0100) begin
      errors++;
      $display("FAIL evt_setpulse: got %h want 4",
               aIf.keyPressPulse);
    end
    step();
    aIf.evtClrEn = 1'b0;
    aIf.evtClrMask = 4'b0000;
    checks++;
    if (aIf.keyOut !== 32'h24) begin
      errors++;
      $display("FAIL evt_clr2: got %h want 24", aIf.keyOut);
    end
    aIf.keyRaw[2] = 1'b1;
    repeat (D + 3) step();
    checks++;
    if (aIf.keyOut !== 32'h20) begin
      errors++;
      $display("FAIL evt_post: got %h want 20", aIf.keyOut);
    end
  endtask

  task automatic test_switches();
    logic [31:0] exp;
    aIf.swRaw = 10'h2A5;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp = (e >= D + 2) ? 32'h2A5 : 32'h0;
      checks++;
      if (aIf.swOut !== exp) begin
        errors++;
        $display("FAIL sw e=%0d: got %h want %h",
                 e, aIf.swOut, exp);
      end
    end
    aIf.swRaw[9] = 1'b0;
    step();
    step();
    aIf.swRaw[9] = 1'b1;
    repeat (10) begin
      step();
      checks++;
      if (aIf.swOut !== 32'h2A5) begin
        errors++;
        $display("FAIL sw_glitch: got %h want 2a5", aIf.swOut);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    logic [3:0] expP;
    aIf.keyRaw = 4'b0111;
    aIf.swRaw = '0;
    repeat (4) step();
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (aIf.keyOut !== 32'h0 || aIf.swOut !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got %h/%h want 0/0",
               aIf.keyOut, aIf.swOut);
    end
    step();
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp = (e >= D + 2) ? 32'h88 : 32'h0;
      expP = (e == D + 2) ? 4'b1000 : 4'b0000;
      checks++;
      if (aIf.keyOut !== exp) begin
        errors++;
        $display("FAIL rst_press e=%0d: got %h want %h",
                 e, aIf.keyOut, exp);
      end
      checks++;
      if (aIf.keyPressPulse !== expP) begin
        errors++;
        $display("FAIL rst_pulse e=%0d: got %h want %h",
                 e, aIf.keyPressPulse, expP);
      end
    end
  endtask

  task automatic test_dc1();
    logic [31:0] exp;
    logic [3:0] expP;
    for (int r = 0; r < 2; r++) begin
      bIf.keyRaw[3] = 1'b0;
      for (int e = 1; e <= 5; e++) begin
        step();
        exp = (e >= 3) ? 32'h88 : 32'h0;
        expP = (e == 3) ? 4'b1000 : 4'b0000;
        checks++;
        if (bIf.keyOut !== exp) begin
          errors++;
          $display("FAIL dc1_key r=%0d e=%0d: got %h want %h",
                   r, e, bIf.keyOut, exp);
        end
        checks++;
        if (bIf.keyPressPulse !== expP) begin
          errors++;
          $display("FAIL dc1_pulse r=%0d e=%0d: got %h want %h",
                   r, e, bIf.keyPressPulse, expP);
        end
      end
      #2 rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (bIf.keyOut !== 32'h0) begin
        errors++;
        $display("FAIL dc1_reset: got %h want 0", bIf.keyOut);
      end
      step();
      rst = 1'b0;
    end
  endtask

  task automatic test_random();
    int k;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        k = $urandom_range(0, 3);
        aIf.keyRaw[k] = ~aIf.keyRaw[k];
      end
      if ($urandom_range(0, 5) == 0) begin
        k = $urandom_range(0, 9);
        aIf.swRaw[k] = ~aIf.swRaw[k];
      end
      aIf.evtClrEn = ($urandom_range(0, 7) == 0);
      aIf.evtClrMask = 4'($urandom);
      step();
      checks++;
      if (aIf.keyOut !== expKey()) begin
        errors++;
        $display("FAIL rnd_key c=%0d: got %h want %h",
                 c, aIf.keyOut, expKey());
      end
      checks++;
      if (aIf.swOut !== expSw()) begin
        errors++;
        $display("FAIL rnd_sw c=%0d: got %h want %h",
                 c, aIf.swOut, expSw());
      end
      checks++;
      if (aIf.keyPressPulse !== mPulse) begin
        errors++;
        $display("FAIL rnd_pulse c=%0d: got %h want %h",
                 c, aIf.keyPressPulse, mPulse);
      end
    end
    aIf.evtClrEn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_evt_clear();
    test_switches();
    test_reset_mid();
    test_dc1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
